// File: rtl/arb_mux.sv
// arb_mux: registered N:1 word multiplexer with valid/ready handshaking.
//
// The source channel is either taken from a binary select (mode = 0) or
// picked by a round-robin arbiter among the valid channels (mode = 1).
// The chosen word is captured into a single output register stage.
//
// Ports:
//   clock      in   1             rising-edge clock
//   reset_n    in   1             asynchronous active-low reset
//   mode       in   1             0 = fixed select, 1 = round-robin
//   select     in   SEL_W         channel index used in fixed mode
//   in_data    in   NUM_IN*WIDTH  channel k at [k*WIDTH +: WIDTH]
//   in_valid   in   NUM_IN        per-channel valid
//   in_ready   out  NUM_IN        per-channel ready (one-hot or zero)
//   out_data   out  WIDTH         registered output word
//   out_src    out  SEL_W         channel that supplied out_data
//   out_valid  out  1             out_data holds an untaken word
//   out_ready  in   1             downstream accepts the word
module arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        select,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic              load;
  logic              xfer;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant;
  logic [SEL_W-1:0]  ptr;
  logic [WIDTH-1:0]  grant_data;

  logic [NUM_IN-1:0] hi_valid;
  logic              hi_any;
  logic [SEL_W-1:0]  hi_idx;
  logic [SEL_W-1:0]  lo_idx;
  logic [SEL_W-1:0]  rr_grant;
  logic              fixed_valid;

  assign load = !out_valid || out_ready;
  assign xfer = load && grant_valid;

  // Round-robin: channels at or above ptr are searched first; if none of
  // them is valid the search wraps to the lowest valid channel overall.
  always_comb begin
    hi_valid = '0;
    hi_any   = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      hi_valid[k] = in_valid[k] && (SEL_W'(k) >= ptr);
    end
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (hi_valid[k]) begin
        hi_idx = SEL_W'(k);
        hi_any = 1'b1;
      end
      if (in_valid[k]) begin
        lo_idx = SEL_W'(k);
      end
    end
    rr_grant = hi_any ? hi_idx : lo_idx;
  end

  // A select value with no matching channel simply yields no grant.
  always_comb begin
    fixed_valid = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (SEL_W'(k) == select) begin
        fixed_valid = in_valid[k];
      end
    end
  end

  always_comb begin
    if (mode) begin
      grant       = rr_grant;
      grant_valid = |in_valid;
    end else begin
      grant       = select;
      grant_valid = fixed_valid;
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (SEL_W'(k) == grant) begin
        grant_data  = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = xfer;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= grant_data;
        out_src  <= grant;
        if (mode) begin
          ptr <= (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed bench for arb_mux with a scoreboard per instance.
// Instance A: WIDTH=32, NUM_IN=8, SEL_W=4. Instance B: WIDTH=16, NUM_IN=3,
// SEL_W=2. Stimulus pushes the expected (src, data) of every word it expects
// to be accepted; a monitor pops one entry per output handshake.
module tb_arb_mux;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int seq   = 0;

  // instance A
  logic         a_mode;
  logic [3:0]   a_sel;
  logic [255:0] a_data;
  logic [7:0]   a_valid;
  logic [7:0]   a_rdy;
  logic [31:0]  a_out_data;
  logic [3:0]   a_out_src;
  logic         a_out_valid;
  logic         a_out_ready;

  // instance B
  logic         b_mode;
  logic [1:0]   b_sel;
  logic [47:0]  b_data;
  logic [2:0]   b_valid;
  logic [2:0]   b_rdy;
  logic [15:0]  b_out_data;
  logic [1:0]   b_out_src;
  logic         b_out_valid;
  logic         b_out_ready;

  int          qa_src[$];
  logic [31:0] qa_dat[$];
  int          qb_src[$];
  logic [15:0] qb_dat[$];

  arb_mux #(.WIDTH(32), .NUM_IN(8), .SEL_W(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .mode(a_mode), .select(a_sel),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_rdy),
    .out_data(a_out_data), .out_src(a_out_src), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  arb_mux #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .mode(b_mode), .select(b_sel),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_rdy),
    .out_data(b_out_data), .out_src(b_out_src), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  function automatic logic [31:0] a_word(input int k);
    return {seq[15:0], 16'h0100 + 16'(k)};
  endfunction

  function automatic logic [15:0] b_word(input int k);
    return {seq[7:0], 8'(k)};
  endfunction

  always_comb begin
    a_data = '0;
    b_data = '0;
    for (int k = 0; k < 8; k++) a_data[k*32 +: 32] = a_word(k);
    for (int k = 0; k < 3; k++) b_data[k*16 +: 16] = b_word(k);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors sample on the falling edge; a handshake seen here completes on
  // the following rising edge.
  always @(negedge clock) begin
    if (reset_n && a_out_valid && a_out_ready) begin
      if (qa_src.size() == 0) begin
        chk("a_unexpected_word", 64'(qa_src.size()), 64'd1);
      end else begin
        chk("a_out_src", 64'(a_out_src), 64'(qa_src.pop_front()));
        chk("a_out_data", 64'(a_out_data), 64'(qa_dat.pop_front()));
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && b_out_valid && b_out_ready) begin
      if (qb_src.size() == 0) begin
        chk("b_unexpected_word", 64'(qb_src.size()), 64'd1);
      end else begin
        chk("b_out_src", 64'(b_out_src), 64'(qb_src.pop_front()));
        chk("b_out_data", 64'(b_out_data), 64'(qb_dat.pop_front()));
      end
    end
  end

  // Called at posedge+1 with inputs set; exp_src < 0 means no acceptance.
  task automatic a_step(input int exp_src);
    logic [7:0] exp_rdy;
    #1;
    exp_rdy = (exp_src >= 0) ? 8'(1 << exp_src) : 8'h00;
    chk("a_in_ready", 64'(a_rdy), 64'(exp_rdy));
    if (exp_src >= 0) begin
      qa_src.push_back(exp_src);
      qa_dat.push_back(a_word(exp_src));
    end
    @(posedge clock);
    #1;
    seq++;
  endtask

  task automatic b_step(input int exp_src);
    logic [2:0] exp_rdy;
    #1;
    exp_rdy = (exp_src >= 0) ? 3'(1 << exp_src) : 3'b000;
    chk("b_in_ready", 64'(b_rdy), 64'(exp_rdy));
    if (exp_src >= 0) begin
      qb_src.push_back(exp_src);
      qb_dat.push_back(b_word(exp_src));
    end
    @(posedge clock);
    #1;
    seq++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_data;
    logic [3:0]  hold_src;

    reset_n     = 1'b0;
    a_mode      = 1'b1;
    a_sel       = 4'd0;
    a_valid     = 8'hff;
    a_out_ready = 1'b1;
    b_mode      = 1'b1;
    b_sel       = 2'd0;
    b_valid     = 3'b000;
    b_out_ready = 1'b1;

    @(posedge clock);
    #1;
    chk("reset_out_valid", 64'(a_out_valid), 64'd0);
    chk("reset_out_src", 64'(a_out_src), 64'd0);
    chk("reset_out_data", 64'(a_out_data), 64'd0);
    reset_n = 1'b1;

    // round-robin fairness, all channels valid
    for (int k = 0; k < 8; k++) a_step(k);
    a_step(0);

    // asynchronous reset with a word pending; ptr (now 1) must return to 0
    chk("pre_reset_valid", 64'(a_out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(a_out_valid), 64'd0);
    chk("async_reset_src", 64'(a_out_src), 64'd0);
    chk("async_reset_data", 64'(a_out_data), 64'd0);
    qa_src.delete();
    qa_dat.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    a_step(0);
    a_step(1);

    // fixed mode
    a_mode = 1'b0;
    a_sel  = 4'd5;
    repeat (3) a_step(5);
    a_sel = 4'd9;
    a_step(-1);
    chk("oob_select_valid", 64'(a_out_valid), 64'd0);
    a_step(-1);

    // bring ptr to 0 via a grant on channel 7, then skip/wrap
    a_mode  = 1'b1;
    a_valid = 8'h80;
    a_step(7);
    a_valid = 8'b1000_0100;
    a_step(2);
    a_step(7);
    a_step(2);
    a_step(7);
    a_valid = 8'b0000_0100;
    a_step(2);
    a_step(2);

    // backpressure; ptr is 3 here
    a_valid = 8'hff;
    a_step(3);
    hold_data   = a_out_data;
    hold_src    = a_out_src;
    a_out_ready = 1'b0;
    repeat (3) begin
      a_step(-1);
      chk("bp_valid", 64'(a_out_valid), 64'd1);
      chk("bp_src", 64'(a_out_src), 64'(hold_src));
      chk("bp_data", 64'(a_out_data), 64'(hold_data));
    end
    a_out_ready = 1'b1;
    a_step(4);
    a_step(5);
    a_valid = 8'h00;
    a_step(-1);
    a_step(-1);
    chk("a_drained_valid", 64'(a_out_valid), 64'd0);
    chk("a_queue_empty", 64'(qa_src.size()), 64'd0);

    // parameter sweep instance: 3 channels
    b_valid = 3'b111;
    b_step(0);
    b_step(1);
    b_step(2);
    b_step(0);
    b_valid = 3'b000;
    b_step(-1);
    b_step(-1);
    chk("b_drained_valid", 64'(b_out_valid), 64'd0);
    chk("b_queue_empty", 64'(qb_src.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised, registered N:1 datapath multiplexer with valid/ready handshaking. Each input channel offers WIDTH-bit words, and the block forwards one word per cycle into a single output register. The source channel is chosen in one of two ways:
- **Fixed-select mode:** a binary `select` input picks the channel.
- **Round-robin mode:** a fair arbiter picks among the valid channels.

It replaces the purely combinational 8-way word mux wherever sources are decoupled producers (load/store return, writeback sharing, debug taps) and backpressure is needed.

## Interface
- `WIDTH`, default 32: data word width in bits.
- `NUM_IN`, default 8: number of input channels, 2 or more; need not be a power of two.
- `SEL_W`, default 3: width of `select` and `out_src`; must satisfy 2^SEL_W >= NUM_IN.

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `mode`  in  1: 0 = fixed select, 1 = round-robin.
- `select`  in  SEL_W: channel index used in fixed mode.
- `in_data`  in  NUM_IN*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`  in  NUM_IN: per-channel valid.
- `in_ready`  out  NUM_IN: per-channel ready; at most one bit is high at a time.
- `out_data`  out  WIDTH: registered output word.
- `out_src`  out  SEL_W: index of the channel that supplied `out_data`.
- `out_valid`  out  1: `out_data` holds an untaken word.
- `out_ready`  in  1: downstream accepts the word.

## Operation
- **Output register:** `out_data`, `out_src` and `out_valid` form one pipeline stage.
  - `load = !out_valid || out_ready`.
  - A transfer on input channel g occurs when `load && in_valid[g] && g == grant`.
- **Ready:** `in_ready[g] = load && (g == grant) && grant_valid`. All other bits are 0. `in_ready` is combinational from `out_ready`; there is no skid buffer.
- **Fixed mode (`mode` = 0):**
  - `grant = select`.
  - `grant_valid = in_valid[select]`.
  - If `select` >= NUM_IN, then `grant_valid = 0`, nothing is accepted and no error is raised.
- **Round-robin mode (`mode` = 1):**
  - `grant` is the lowest index k in the cyclic order ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1 with `in_valid[k] = 1`.
  - `grant_valid` = OR of all `in_valid` bits.
- **Priority pointer `ptr`** (internal, range 0..NUM_IN-1):
  - Updates only on a transfer made in round-robin mode: `ptr <= (grant == NUM_IN-1) ? 0 : grant+1`.
  - It is unchanged in fixed mode and on idle cycles.
- **On a transfer:** `out_data <= in_data[grant]`, `out_src <= grant`, `out_valid <= 1`.
- **When `load` is true but nothing is granted:** `out_valid <= 0`, and `out_data`/`out_src` hold their old values.
- **When `out_valid && !out_ready`:** all output registers hold and every `in_ready` bit is 0.
- **`mode`/`select` changes:** sampled combinationally every cycle. A change takes effect on the next grant, and an already-registered word is never affected.
- **Reset (asynchronous, any time):**
  - `out_valid = 0`, `out_data = 0`, `out_src = 0`, `ptr = 0`.
  - A word pending in the output register is dropped.

## Timing
- Latency is 1 cycle: a word accepted at edge n appears on `out_data` with `out_valid` = 1 after edge n.
- Throughput is 1 word per cycle while `out_ready` is held high.
- Round-robin grant is combinational over NUM_IN bits, with no extra pipeline stage.
- Reset deassertion is assumed synchronised externally. The first transfer is possible at the first rising edge after `reset_n` rises.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-stream with `out_valid` = 1 → `out_valid`, `out_data`, `out_src` all 0 immediately, without waiting for a clock edge. After release, in round-robin mode with all inputs valid, the first grant is channel 0.
- **Fixed mode:** `mode` = 0, `select` = 5, all valid, `in_data[k]` = 0x100+k, `out_ready` = 1 → `out_data` = 0x105 and `out_src` = 5 every cycle, with `in_ready` = 8'b0010_0000. Then `select` = 9 with NUM_IN = 8 and SEL_W = 4 → `out_valid` falls after one cycle and `in_ready` = 0.
- **Round-robin fairness:** `mode` = 1, all 8 valid, `out_ready` = 1 → `out_src` sequence 0,1,…,7,0 on consecutive cycles.
- **Round-robin skip and wrap:** `in_valid` = 8'b1000_0100 with ptr = 0 → grants 2, 7, 2, 7. Then drop `in_valid[7]` → grants 2, 2.
- **Backpressure:** `out_ready` = 0 for 3 cycles with `out_valid` = 1 → `out_data`/`out_src` stable, `in_ready` = 0, ptr unchanged. Raising `out_ready` resumes from the next round-robin channel with no word lost or duplicated.
- **Parameter sweep:** NUM_IN = 3, WIDTH = 16, SEL_W = 2, round-robin with all valid → `out_src` sequence 0,1,2,0. A scoreboard checks that each accepted word is output exactly once.
